pool_stream_engine: RTL and testbench
=====================================

Name: pool_stream_engine

Overview:
- Streaming 2D pooling engine, parametrised successor to the fixed 4-wide, single-channel 2x2/stride-2 max-pool stage.
- Takes conv-layer OFMAP pixels in raster order, CHANNELS lanes in parallel, with valid/ready handshakes.
- Runs max or average pooling per frame and emits pooled pixels to the dense-layer input.
- Sits between the convolution output and the fully-connected layer in the CNN datapath.

Parameters:
- DATA_WIDTH, 8, signed two's-complement width per channel element
- CHANNELS, 4, parallel feature-map channels per pixel beat
- ARRAY_WIDTH, 4, input frame width in pixels
- ARRAY_HEIGHT, 4, input frame height in pixels
- POOL_SIZE, 2, square window edge; power of 2, 2..8; stride equals POOL_SIZE (non-overlapping)
- RESULT_WIDTH, ARRAY_WIDTH/POOL_SIZE (derived, localparam), pooled columns per row
- RESULT_HEIGHT, ARRAY_HEIGHT/POOL_SIZE (derived, localparam), pooled rows per frame

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode_avg  in  1  0 = max, 1 = average; sampled on first accepted pixel of each frame
- in_valid  in  1  input beat valid
- in_ready  out  1  engine can accept beat
- in_data  in  CHANNELS*DATA_WIDTH  packed pixel; channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  pooled beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  CHANNELS*DATA_WIDTH  pooled pixel, same packing
- out_last  out  1  high with the final pooled beat of a frame
- frame_done  out  1  one-cycle pulse when the last input pixel of a frame is accepted

Behaviour:
- Reset (async assert, sync release): all outputs 0; col/row counters 0; partial buffers cleared; in_ready 0 during reset, 1 the first cycle after.
- Transfer occurs when valid && ready on the same edge.
- in_ready = !out_valid || out_ready. This is a single output register; no skid.
- Counters:
  - col 0..ARRAY_WIDTH-1 increments per accepted beat; wraps to 0 and increments row.
  - row wraps 0 after ARRAY_HEIGHT-1 (end of frame).
- Window index: wc = col/POOL_SIZE, wr = row/POOL_SIZE.
  - Pixels with wc >= RESULT_WIDTH or wr >= RESULT_HEIGHT (non-multiple remainder) are accepted and discarded.
- Partial buffer: RESULT_WIDTH entries x CHANNELS.
  - Max mode stores a running max (DATA_WIDTH).
  - Avg mode stores a running sum of width DATA_WIDTH+2*log2(POOL_SIZE), sign-extended.
  - The first pixel of a window (row%P==0 && col%P==0) overwrites the entry; later pixels accumulate.
- Completion: accepting the window's last pixel (row%P==P-1, col%P==P-1) loads out_data the next cycle; out_valid=1.
  - Latency is 1 cycle from the completing input to out_valid.
- Avg result = sum >>> (2*log2(POOL_SIZE)), arithmetic (floor), truncated to DATA_WIDTH; no overflow is possible.
- Max compare is signed.
- out_last = 1 on the beat for window (RESULT_WIDTH-1, RESULT_HEIGHT-1).
- out_valid/out_data/out_last stay stable while out_valid && !out_ready.
- frame_done pulses on acceptance of pixel (ARRAY_WIDTH-1, ARRAY_HEIGHT-1), independent of output stall.
- Mode change mid-frame is ignored until the next frame's first pixel.
- Reset mid-frame discards all partial state and any pending output; the next accepted pixel is (0,0).
- Simultaneous out-handshake and new completing input is legal: the register reloads in the same cycle.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: fused ReLU on the output. Any negative pooled value is replaced by 0 before the output register, in both modes.
- Undefined: signed results pass unchanged.

Decomposition:
- Shared package (extend the project params package) holds:
  - DATA_WIDTH, CHANNELS, ARRAY_WIDTH/HEIGHT and POOL_SIZE defaults
  - a typedef enum logic {POOL_MAX, POOL_AVG} pool_mode_e
  - a function clog2-based ACC_WIDTH(DATA_WIDTH, POOL_SIZE)
- One natural sub-module: pool_lane.
  - Per-channel compare/accumulate and finalise (max/sum, shift, ReLU), instantiated CHANNELS times with generate.
  - Counters, buffer addressing and handshake stay in the top.

Test Plan:
- 4x4 frame, CHANNELS=1, values 1..16 raster, max mode -> outputs 6, 8, 14, 16. out_last on 16; frame_done on 16th input.
- Same frame, avg mode -> 3, 5, 11, 13 (floor of 3.5, 5.5, 11.5, 13.5).
- Window {-3,-1,-2,-4}: max -> -1; avg -> -3 (floor -2.5). With POOL_RELU_EN both -> 0.
- out_ready held 0 for 3 cycles after first out_valid, in_valid continuous -> in_ready 0 while stalled, out_data stable, no beat lost; output order unchanged.
- ARRAY_WIDTH=5, ARRAY_HEIGHT=5, POOL_SIZE=2 -> RESULT 2x2. Column 4 and row 4 pixels consumed, no output; 4 beats per frame.
- rst_n asserted after 6 accepted pixels -> outputs 0 immediately. Fresh frame 1..16 yields 6, 8, 14, 16 with no stale partials.

Source files
------------

// File: rtl/pool_stream_engine_pkg.sv
// Shared parameters, types and helpers for the streaming pooling engine.
package pool_stream_engine_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_CHANNELS     = 4;
  localparam int unsigned DEF_ARRAY_WIDTH  = 4;
  localparam int unsigned DEF_ARRAY_HEIGHT = 4;
  localparam int unsigned DEF_POOL_SIZE    = 2;

  typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;

  // Window sum width: P*P samples need 2*log2(P) guard bits.
  function automatic int unsigned acc_width(int unsigned dw, int unsigned ps);
    return dw + 2 * $clog2(ps);
  endfunction

endpackage

// File: rtl/pool_stream_engine_pool_lane.sv
// One channel of the pooling datapath: running max/sum update and result finalise.
// Optional fused ReLU is enabled by defining POOL_RELU_EN.
module pool_stream_engine_pool_lane
  import pool_stream_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned POOL_SIZE  = DEF_POOL_SIZE,
  parameter int unsigned ACC_W      = acc_width(DEF_DATA_WIDTH, DEF_POOL_SIZE)
) (
  input  logic                  mode_avg,
  input  logic                  first,
  input  logic [DATA_WIDTH-1:0] pix,
  input  logic [ACC_W-1:0]      acc,
  output logic [ACC_W-1:0]      acc_next_c,
  output logic [DATA_WIDTH-1:0] result_c
);

  localparam int unsigned SHIFT = 2 * $clog2(POOL_SIZE);

  logic signed [DATA_WIDTH-1:0] pix_s;
  logic signed [DATA_WIDTH-1:0] max_s;
  logic signed [DATA_WIDTH-1:0] res_s;
  logic signed [ACC_W-1:0]      pix_ext;
  logic signed [ACC_W-1:0]      sum_s;
  logic signed [ACC_W-1:0]      avg_s;

  // Merge the incoming sample into the window state and derive the pooled value.
  always_comb begin
    pix_s   = $signed(pix);
    pix_ext = ACC_W'(pix_s);
    max_s   = $signed(acc[DATA_WIDTH-1:0]);
    if (first || (pix_s > max_s)) max_s = pix_s;
    sum_s   = first ? pix_ext : ($signed(acc) + pix_ext);
    acc_next_c = mode_avg ? sum_s : ACC_W'(max_s);
    avg_s   = sum_s >>> SHIFT;
    res_s   = mode_avg ? $signed(avg_s[DATA_WIDTH-1:0]) : max_s;
`ifdef POOL_RELU_EN
    if (res_s < 0) res_s = '0;
`else
`endif
    result_c = res_s;
  end

endmodule

// File: rtl/pool_stream_engine.sv
// Streaming 2D max/average pooling engine with valid/ready handshakes.
// Define POOL_RELU_EN to clamp negative pooled results to zero.
module pool_stream_engine
  import pool_stream_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned CHANNELS     = DEF_CHANNELS,
  parameter int unsigned ARRAY_WIDTH  = DEF_ARRAY_WIDTH,
  parameter int unsigned ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
  parameter int unsigned POOL_SIZE    = DEF_POOL_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode_avg,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         frame_done
);

  localparam int unsigned RESULT_WIDTH  = ARRAY_WIDTH / POOL_SIZE;
  localparam int unsigned RESULT_HEIGHT = ARRAY_HEIGHT / POOL_SIZE;
  localparam int unsigned ACC_W   = acc_width(DATA_WIDTH, POOL_SIZE);
  localparam int unsigned PS_LOG  = $clog2(POOL_SIZE);
  localparam int unsigned COL_W   = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
  localparam int unsigned ROW_W   = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
  localparam int unsigned IDX_W   = (RESULT_WIDTH > 1) ? $clog2(RESULT_WIDTH) : 1;
  localparam int unsigned BUS_W   = CHANNELS * DATA_WIDTH;
  localparam int unsigned BUF_W   = CHANNELS * ACC_W;

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             ready_en_q;
  pool_mode_e       mode_q;
  logic [BUF_W-1:0] buf_q [RESULT_WIDTH];

  logic [31:0]      col_ext;
  logic [31:0]      row_ext;
  pool_mode_e       mode_c;
  logic             fire_c;
  logic             frame_start_c;
  logic             col_end_c;
  logic             row_end_c;
  logic             in_win_c;
  logic             win_first_c;
  logic             win_last_c;
  logic             res_last_c;
  logic [IDX_W-1:0] wc_idx_c;
  logic [BUF_W-1:0] acc_next_c;
  logic [BUS_W-1:0] result_c;

  // Single output register: accept whenever it is empty or draining this cycle.
  assign in_ready = ready_en_q && (!out_valid || out_ready);

  // Position decode for the current raster pixel.
  always_comb begin
    col_ext       = 32'(col_q);
    row_ext       = 32'(row_q);
    fire_c        = in_valid && in_ready;
    frame_start_c = (col_q == '0) && (row_q == '0);
    mode_c        = frame_start_c ? pool_mode_e'(mode_avg) : mode_q;
    col_end_c     = (col_ext == ARRAY_WIDTH - 1);
    row_end_c     = (row_ext == ARRAY_HEIGHT - 1);
    in_win_c      = ((col_ext >> PS_LOG) < RESULT_WIDTH) && ((row_ext >> PS_LOG) < RESULT_HEIGHT);
    win_first_c   = ((col_ext % POOL_SIZE) == 0) && ((row_ext % POOL_SIZE) == 0);
    win_last_c    = ((col_ext % POOL_SIZE) == POOL_SIZE - 1) &&
                    ((row_ext % POOL_SIZE) == POOL_SIZE - 1);
    res_last_c    = ((col_ext >> PS_LOG) == RESULT_WIDTH - 1) &&
                    ((row_ext >> PS_LOG) == RESULT_HEIGHT - 1);
    wc_idx_c      = in_win_c ? IDX_W'(col_ext >> PS_LOG) : '0;
  end

  // Per-channel compare/accumulate lanes.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool_stream_engine_pool_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .POOL_SIZE  (POOL_SIZE),
      .ACC_W      (ACC_W)
    ) u_lane (
      .mode_avg   (mode_c == POOL_AVG),
      .first      (win_first_c),
      .pix        (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .acc        (buf_q[wc_idx_c][c*ACC_W +: ACC_W]),
      .acc_next_c (acc_next_c[c*ACC_W +: ACC_W]),
      .result_c   (result_c[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Raster counters, frame mode latch and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      mode_q     <= POOL_MAX;
      ready_en_q <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      frame_done <= fire_c && col_end_c && row_end_c;
      if (fire_c) begin
        if (frame_start_c) mode_q <= mode_c;
        if (col_end_c) begin
          col_q <= '0;
          row_q <= row_end_c ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // Partial window buffer, one entry per pooled column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RESULT_WIDTH; i++) buf_q[i] <= '0;
    end else if (fire_c && in_win_c) begin
      buf_q[wc_idx_c] <= acc_next_c;
    end
  end

  // Output register: load on window completion, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (fire_c && in_win_c && win_last_c) begin
      out_valid <= 1'b1;
      out_data  <= result_c;
      out_last  <= res_last_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_stream_engine.sv
// Directed bench for pool_stream_engine: 4x4 two-channel and 5x5 single-channel instances.
module tb_pool_stream_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4x4 frame, two channels
  logic        a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_frame_done;
  logic [15:0] a_in_data, a_out_data;
  // 5x5 frame, one channel
  logic        b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_frame_done;
  logic [7:0]  b_in_data, b_out_data;

  pool_stream_engine #(.DATA_WIDTH(8), .CHANNELS(2), .ARRAY_WIDTH(4), .ARRAY_HEIGHT(4), .POOL_SIZE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode_avg(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .frame_done(a_frame_done));

  pool_stream_engine #(.DATA_WIDTH(8), .CHANNELS(1), .ARRAY_WIDTH(5), .ARRAY_HEIGHT(5), .POOL_SIZE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode_avg(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .frame_done(b_frame_done));

  typedef struct {
    logic mode;
    int   base;
    int   w0, w1, w2, w3;
    int   e0, e1, e2, e3;
    int   ew;
  } vec_t;

  vec_t vecs[5];
  int checks = 0;
  int errors = 0;
  int a_q0[$], a_q1[$], a_ql[$];
  int b_q[$], b_ql[$];
  int a_fd_cnt = 0;
  int b_fd_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int post(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Output monitors sample mid low-phase, after stimulus settles.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && a_out_valid && a_out_ready) begin
      a_q0.push_back(int'($signed(a_out_data[7:0])));
      a_q1.push_back(int'($signed(a_out_data[15:8])));
      a_ql.push_back(int'(a_out_last));
    end
    if (rst_n && a_frame_done) begin
      a_fd_cnt++;
      check("a_frame_done_with_last", int'(a_out_valid && a_out_last), 1);
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      b_q.push_back(int'($signed(b_out_data)));
      b_ql.push_back(int'(b_out_last));
    end
    if (rst_n && b_frame_done) b_fd_cnt++;
  end

  task automatic push_a(input logic md, input logic [15:0] d);
    int n;
    n = 0;
    a_mode = md; a_in_data = d; a_in_valid = 1'b1;
    #3;
    while (!a_in_ready && n < 50) begin @(negedge clk); #3; n++; end
    if (!a_in_ready) check("a_push_timeout", int'(a_in_ready), 1);
    @(negedge clk);
  endtask

  task automatic push_b(input logic md, input logic [7:0] d);
    int n;
    n = 0;
    b_mode = md; b_in_data = d; b_in_valid = 1'b1;
    #3;
    while (!b_in_ready && n < 50) begin @(negedge clk); #3; n++; end
    if (!b_in_ready) check("b_push_timeout", int'(b_in_ready), 1);
    @(negedge clk);
  endtask

  // Mode is flipped after the first pixel to confirm it is latched per frame.
  task automatic run_vec(input vec_t v);
    int p0, p1;
    for (int i = 0; i < 16; i++) begin
      p0 = v.base + i + 1;
      case (i)
        0: p1 = v.w0;
        1: p1 = v.w1;
        4: p1 = v.w2;
        5: p1 = v.w3;
        default: p1 = 0;
      endcase
      push_a((i == 0) ? v.mode : ~v.mode, {8'(p1), 8'(p0)});
    end
    a_in_valid = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    int e0[4];
    int k;
    k = 0;
    e0 = '{v.e0, v.e1, v.e2, v.e3};
    while (a_q0.size() < 4 && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    check($sformatf("%s beats", tag), a_q0.size(), 4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("%s ch0[%0d]", tag, j), a_q0[j], post(e0[j]));
      check($sformatf("%s ch1[%0d]", tag, j), a_q1[j], (j == 0) ? post(v.ew) : 0);
      check($sformatf("%s last[%0d]", tag, j), a_ql[j], (j == 3) ? 1 : 0);
    end
    a_q0.delete(); a_q1.delete(); a_ql.delete();
  endtask

  task automatic run_b(input logic md, input int exp[4], input string tag);
    int fd0;
    fd0 = b_fd_cnt;
    for (int i = 0; i < 25; i++) push_b(md, 8'(i + 1));
    b_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check($sformatf("%s beats", tag), b_q.size(), 4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("%s data[%0d]", tag, j), b_q[j], exp[j]);
      check($sformatf("%s last[%0d]", tag, j), b_ql[j], (j == 3) ? 1 : 0);
    end
    check($sformatf("%s frame_done", tag), b_fd_cnt - fd0, 1);
    b_q.delete(); b_ql.delete();
  endtask

  initial begin
    int fd0;
    int bexp[4];
    logic [15:0] held;
    vecs[0] = '{1'b0,    0,   -3,  -1,   -2,   -4,    6,   8,  14,  16,   -1};
    vecs[1] = '{1'b1,    0,   -3,  -1,   -2,   -4,    3,   5,  11,  13,   -3};
    vecs[2] = '{1'b0,  -20,  100, 127, -128,    5,  -14, -12,  -6,  -4,  127};
    vecs[3] = '{1'b1,  -20,  127, 127,  127,  127,  -17, -15,  -9,  -7,  127};
    vecs[4] = '{1'b1,  100, -128,-128, -128, -128,  103, 105, 111, 113, -128};

    rst_n = 1'b0;
    a_mode = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    #1;
    check("rst a_out_valid", int'(a_out_valid), 0);
    check("rst a_out_data", int'(a_out_data), 0);
    check("rst a_in_ready", int'(a_in_ready), 0);
    check("rst a_frame_done", int'(a_frame_done), 0);
    check("rst b_in_ready", int'(b_in_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post-rst a_in_ready", int'(a_in_ready), 1);
    check("post-rst b_in_ready", int'(b_in_ready), 1);
    @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      fd0 = a_fd_cnt;
      run_vec(vecs[v]);
      check_vec(vecs[v], $sformatf("vec%0d", v));
      check($sformatf("vec%0d frame_done", v), a_fd_cnt - fd0, 1);
    end

    // Output stall with continuous input
    fork
      run_vec(vecs[0]);
      begin
        int n;
        n = 0;
        while (!a_out_valid && n < 100) begin @(negedge clk); n++; end
        a_out_ready = 1'b0;
        held = a_out_data;
        check("stall first beat", int'($signed(held[7:0])), 6);
        for (int k = 0; k < 3; k++) begin
          #3;
          check("stall in_ready", int'(a_in_ready), 0);
          check("stall out_valid", int'(a_out_valid), 1);
          check("stall out_data", int'(a_out_data), int'(held));
          @(negedge clk);
        end
        a_out_ready = 1'b1;
      end
    join
    check_vec(vecs[0], "stall");

    // Reset mid-frame drops partial state and the pending beat
    for (int i = 0; i < 6; i++) push_a(1'b0, {8'd0, 8'(i + 1)});
    a_in_valid = 1'b0;
    check("pre-rst out_valid", int'(a_out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", int'(a_out_valid), 0);
    check("midrst out_data", int'(a_out_data), 0);
    check("midrst in_ready", int'(a_in_ready), 0);
    check("midrst out_last", int'(a_out_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_q0.delete(); a_q1.delete(); a_ql.delete();
    b_q.delete(); b_ql.delete();
    run_vec(vecs[0]);
    check_vec(vecs[0], "after-rst");

    // 5x5 frame: remainder column/row consumed without output
    bexp = '{7, 9, 17, 19};
    run_b(1'b0, bexp, "b-max");
    bexp = '{4, 6, 14, 16};
    run_b(1'b1, bexp, "b-avg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
